// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Multi-port integer register file for the decode/writeback stages.
//   - NRD combinational read ports, NWR write ports. When several ports write
//     the same register in one cycle, the highest-index port wins.
//   - Optional write-to-read bypass (BYPASS=1): a read sees same-cycle write
//     data from the arbitration winner.
//   - Register 0 is hardwired to zero. Writes to it are discarded.
//   - The storage array has no per-bit reset. After reset, a sweep clears
//     registers 1..NREGS-1, one per clock. ready rises when the sweep is done.
//
// Ports
//   clk    in   1          clock, rising edge
//   rst    in   1          synchronous active-high reset
//   ra     in   NRD*AW     read addresses, port i at [i*AW +: AW]
//   rd     out  NRD*XLEN   read data, port i at [i*XLEN +: XLEN]
//   we     in   NWR        write enables
//   wa     in   NWR*AW     write addresses, port j at [j*AW +: AW]
//   wd     in   NWR*XLEN   write data, port j at [j*XLEN +: XLEN]
//   ready  out  1          clear sweep finished; writes are accepted
//
// States
//   state | meaning
//   CLEAR | sweeping idx through 1..NREGS-1, writes dropped, reads return 0
//   READY | normal operation
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    output logic                ready
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [AW-1:0] IDX_FIRST = AW'(1);
    localparam logic [AW-1:0] IDX_LAST  = AW'(NREGS - 1);

    state_t         state_q, state_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [XLEN-1:0] regs_q [NREGS];

    logic [AW-1:0]   ra_a [NRD];
    logic [AW-1:0]   wa_a [NWR];
    logic [XLEN-1:0] wd_a [NWR];

    for (genvar i = 0; i < NRD; i++) begin : g_ra
        assign ra_a[i] = ra[i*AW +: AW];
    end

    for (genvar j = 0; j < NWR; j++) begin : g_wr
        assign wa_a[j] = wa[j*AW +: AW];
        assign wd_a[j] = wd[j*XLEN +: XLEN];
    end

    // Sweep control
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == CLEAR) begin
            if (idx_q == IDX_LAST) begin
                // Hold idx at the last value so it never wraps.
                state_d = READY;
            end else begin
                idx_d = idx_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            idx_q   <= IDX_FIRST;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Storage. Ports are visited in ascending order, so the last
    // non-blocking assignment to a register comes from the highest-index
    // port, and that port wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                regs_q[idx_q] <= '0;
            end else begin
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && (wa_a[j] != '0)) begin
                        regs_q[wa_a[j]] <= wd_a[j];
                    end
                end
            end
        end
    end

    // Combinational reads. The bypass uses the same ascending scan as the
    // write path, so it returns the same winner.
    always_comb begin
        rd = '0;
        for (int i = 0; i < NRD; i++) begin
            automatic logic [XLEN-1:0] val = '0;
            if ((state_q == READY) && (ra_a[i] != '0)) begin
                val = regs_q[ra_a[i]];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (we[j] && (wa_a[j] == ra_a[i])) begin
                            val = wd_a[j];
                        end
                    end
                end
            end
            rd[i*XLEN +: XLEN] = val;
        end
    end

    assign ready = (state_q == READY);

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [2*AW-1:0]   ra;
    logic [1:0]        we;
    logic [2*AW-1:0]   wa;
    logic [2*XLEN-1:0] wd;
    logic [2*XLEN-1:0] rd_b, rd_n;
    logic              ready_b, ready_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_b),
        .we(we), .wa(wa), .wd(wd), .ready(ready_b)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_n),
        .we(we), .wa(wa), .wd(wd), .ready(ready_n)
    );

    typedef struct {
        logic [1:0]      we;
        logic [AW-1:0]   wa0, wa1;
        logic [XLEN-1:0] wd0, wd1;
        logic [AW-1:0]   ra0, ra1;
        logic [XLEN-1:0] e0b, e1b;   // expected rd with BYPASS=1
        logic [XLEN-1:0] e0n, e1n;   // expected rd with BYPASS=0
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    function automatic vec_t mk(logic [1:0] w, logic [AW-1:0] a0, logic [XLEN-1:0] d0,
                                logic [AW-1:0] a1, logic [XLEN-1:0] d1,
                                logic [AW-1:0] r0, logic [AW-1:0] r1,
                                logic [XLEN-1:0] e0b, logic [XLEN-1:0] e1b,
                                logic [XLEN-1:0] e0n, logic [XLEN-1:0] e1n);
        vec_t v;
        v.we = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
        v.ra0 = r0; v.ra1 = r1;
        v.e0b = e0b; v.e1b = e1b; v.e0n = e0n; v.e1n = e1n;
        return v;
    endfunction

    task automatic check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we = '0; wa = '0; wd = '0;
    endtask

    // Counts rising edges from now until each DUT's ready is high (-1 if never).
    task automatic count_ready(output int fb, output int fn);
        fb = -1; fn = -1;
        for (int e = 1; e <= 64; e++) begin
            @(posedge clk); #1;
            if (ready_b && fb < 0) fb = e;
            if (ready_n && fn < 0) fn = e;
            if (fb >= 0 && fn >= 0) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int fb, fn;

        //            we     wa0 wd0           wa1 wd1           ra0 ra1  e0b           e1b           e0n           e1n
        vecs[0]  = mk(2'b00, 0,  0,            0,  0,            5,  5,   0,            0,            0,            0);
        vecs[1]  = mk(2'b01, 7,  32'h12345678, 0,  0,            7,  0,   32'h12345678, 0,            0,            0);
        vecs[2]  = mk(2'b00, 0,  0,            0,  0,            7,  7,   32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);
        vecs[3]  = mk(2'b11, 9,  32'hAAAA0000, 9,  32'h5555FFFF, 9,  0,   32'h5555FFFF, 0,            0,            0);
        vecs[4]  = mk(2'b00, 0,  0,            0,  0,            9,  9,   32'h5555FFFF, 32'h5555FFFF, 32'h5555FFFF, 32'h5555FFFF);
        vecs[5]  = mk(2'b01, 3,  32'h00000001, 0,  0,            3,  7,   32'h00000001, 32'h12345678, 0,            32'h12345678);
        vecs[6]  = mk(2'b01, 3,  32'h00000002, 0,  0,            3,  3,   32'h00000002, 32'h00000002, 32'h00000001, 32'h00000001);
        vecs[7]  = mk(2'b00, 0,  0,            0,  0,            3,  9,   32'h00000002, 32'h5555FFFF, 32'h00000002, 32'h5555FFFF);
        vecs[8]  = mk(2'b11, 0,  32'hFFFFFFFF, 0,  32'hFFFFFFFF, 0,  0,   0,            0,            0,            0);
        vecs[9]  = mk(2'b00, 0,  0,            0,  0,            0,  3,   0,            32'h00000002, 0,            32'h00000002);
        vecs[10] = mk(2'b11, 13, 32'h11112222, 12, 32'h0BADF00D, 12, 13,  32'h0BADF00D, 32'h11112222, 0,            0);
        vecs[11] = mk(2'b00, 0,  0,            0,  0,            13, 12,  32'h11112222, 32'h0BADF00D, 32'h11112222, 32'h0BADF00D);
        vecs[12] = mk(2'b01, 4,  32'h0000CAFE, 0,  0,            4,  0,   32'h0000CAFE, 0,            0,            0);
        vecs[13] = mk(2'b00, 0,  0,            0,  0,            4,  4,   32'h0000CAFE, 32'h0000CAFE, 32'h0000CAFE, 32'h0000CAFE);

        // Reset for 3 cycles
        rst = 1'b1; idle_inputs(); ra = {5'd5, 5'd5};
        repeat (3) @(posedge clk);
        #1;
        check("reset ready byp",   {31'b0, ready_b}, 32'd0);
        check("reset ready nobyp", {31'b0, ready_n}, 32'd0);
        check("reset rd byp",   rd_b[31:0], 32'd0);
        check("reset rd nobyp", rd_n[31:0], 32'd0);

        // Sweep with all ports hammering x5; the writes must be dropped
        @(negedge clk);
        rst = 1'b0; we = 2'b11; wa = {5'd5, 5'd5}; wd = {32'hDEADBEEF, 32'hDEADBEEF};
        #1;
        check("clear rd byp", rd_b[31:0], 32'd0);
        count_ready(fb, fn);
        check("sweep edges byp",   fb, 32'd31);
        check("sweep edges nobyp", fn, 32'd31);
        @(negedge clk);
        idle_inputs();

        // Table-driven vectors, one cycle each
        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            we = vecs[v].we;
            wa = {vecs[v].wa1, vecs[v].wa0};
            wd = {vecs[v].wd1, vecs[v].wd0};
            ra = {vecs[v].ra1, vecs[v].ra0};
            #1;
            check($sformatf("vec%0d rd0 byp", v),   rd_b[31:0],  vecs[v].e0b);
            check($sformatf("vec%0d rd1 byp", v),   rd_b[63:32], vecs[v].e1b);
            check($sformatf("vec%0d rd0 nobyp", v), rd_n[31:0],  vecs[v].e0n);
            check($sformatf("vec%0d rd1 nobyp", v), rd_n[63:32], vecs[v].e1n);
        end
        @(negedge clk);
        idle_inputs();

        // Reset while READY: ready falls on the next edge, sweep restarts
        rst = 1'b1;
        @(posedge clk); #1;
        check("midop ready falls byp",   {31'b0, ready_b}, 32'd0);
        check("midop ready falls nobyp", {31'b0, ready_n}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_ready(fb, fn);
        check("midop sweep edges byp",   fb, 32'd31);
        check("midop sweep edges nobyp", fn, 32'd31);
        @(negedge clk);
        ra = {5'd7, 5'd4};
        #1;
        check("x4 cleared byp",   rd_b[31:0],  32'd0);
        check("x4 cleared nobyp", rd_n[31:0],  32'd0);
        check("x7 cleared byp",   rd_b[63:32], 32'd0);

        // Reset again partway through a sweep
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("partial sweep ready byp", {31'b0, ready_b}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        count_ready(fb, fn);
        check("restart sweep edges byp",   fb, 32'd31);
        check("restart sweep edges nobyp", fn, 32'd31);

        // Write after restart, then check it landed
        @(negedge clk);
        we = 2'b10; wa = {5'd20, 5'd0}; wd = {32'h00C0FFEE, 32'h0};
        ra = {5'd20, 5'd20};
        #1;
        check("post-restart bypass", rd_b[31:0], 32'h00C0FFEE);
        check("post-restart nobyp",  rd_n[31:0], 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("post-restart stored byp",   rd_b[63:32], 32'h00C0FFEE);
        check("post-restart stored nobyp", rd_n[63:32], 32'h00C0FFEE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
